// File: rtl/lcd_frame_scheduler.sv
// Round-robin frame scheduler feeding a fixed-colour fill frame to an LCD controller.
// One requester owns the display at a time; each frame consumes exactly RESOLUTION pixel strobes.
module lcd_frame_scheduler #(
    parameter int RESOLUTION = 76800,
    parameter int PIXEL_SIZE = 16,
    parameter int N_REQ      = 4
) (
    input  logic                        clk_out,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*PIXEL_SIZE-1:0] color_in,
    input  logic                        px_strobe,
    output logic [PIXEL_SIZE-1:0]       pixel_out,
    output logic                        frame_done,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            ack,
    output logic                        busy
);
    localparam int CW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         pix_cnt;
    logic [IW-1:0]         rr_ptr, owner, win_idx, cand;
    logic [PIXEL_SIZE-1:0] color_q;
    logic [PIXEL_SIZE-1:0] colors [N_REQ];
    logic [N_REQ-1:0]      win_oh;
    logic                  found, last_px;

    for (genvar g = 0; g < N_REQ; g++) begin : g_col
        assign colors[g] = color_in[g*PIXEL_SIZE +: PIXEL_SIZE];
    end

    assign last_px = (pix_cnt == CW'(RESOLUTION - 1));
    assign busy    = (state != IDLE);

    // First requester at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found) win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = STREAM;
            STREAM:  if (px_strobe && last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ack/grant/frame_done change on the last-strobe edge so they are
    // visible during the DONE cycle; the owner can drop req before IDLE.
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            pix_cnt    <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            color_q    <= '0;
            pixel_out  <= '0;
            frame_done <= 1'b1;
            grant      <= '0;
            ack        <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (found) begin
                    color_q    <= colors[win_idx];
                    grant      <= win_oh;
                    owner      <= win_idx;
                    pix_cnt    <= '0;
                    frame_done <= 1'b0;
                end
                STREAM: if (px_strobe) begin
                    pixel_out <= color_q;
                    if (last_px) begin
                        ack        <= grant;
                        grant      <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                DONE: rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Bench for lcd_frame_scheduler: vector table, directed frame scenarios and
// randomized traffic, all compared against a frame-level reference model.
module tb_lcd_frame_scheduler;
    localparam int RES = 8;
    localparam int NR  = 4;
    localparam int PS  = 16;

    logic              clk_out;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*PS-1:0]  color_in;
    logic              px_strobe;
    logic [PS-1:0]     pixel_out;
    logic              frame_done;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     ack;
    logic              busy;

    int vecs = 0;
    int errs = 0;

    lcd_frame_scheduler #(.RESOLUTION(RES), .PIXEL_SIZE(PS), .N_REQ(NR)) dut (
        .clk_out(clk_out), .rst(rst), .req(req), .color_in(color_in),
        .px_strobe(px_strobe), .pixel_out(pixel_out), .frame_done(frame_done),
        .grant(grant), .ack(ack), .busy(busy)
    );

    initial begin
        clk_out = 1'b0;
        forever #5 clk_out = ~clk_out;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Reference model: owner index (-1 none), strobes still owed, and a flag
    // for the single completion cycle after the last pixel.
    int            m_owner = -1;
    bit            m_done  = 1'b0;
    int            m_left  = 0;
    int            m_rr    = 0;
    logic [PS-1:0] m_pix   = '0;
    logic [PS-1:0] m_col   = '0;

    task automatic model_step();
        bit hit;
        int i;
        if (!rst) begin
            m_owner = -1; m_done = 1'b0; m_left = 0; m_rr = 0; m_pix = '0; m_col = '0;
        end else if (m_done) begin
            m_rr    = (m_owner + 1) % NR;
            m_owner = -1;
            m_done  = 1'b0;
        end else if (m_owner >= 0) begin
            if (px_strobe) begin
                m_pix  = m_col;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end else begin
            hit = 1'b0;
            for (int k = 0; k < NR; k++) begin
                i = (m_rr + k) % NR;
                if (!hit && req[i]) begin
                    hit     = 1'b1;
                    m_owner = i;
                    m_col   = color_in[i*PS +: PS];
                    m_left  = RES;
                end
            end
        end
    endtask

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    task automatic check_model();
        bit            strm;
        logic [NR-1:0] eg, ea;
        strm = (m_owner >= 0) && !m_done;
        eg   = strm   ? NR'(1 << m_owner) : '0;
        ea   = m_done ? NR'(1 << m_owner) : '0;
        vecs++;
        if (pixel_out !== m_pix || frame_done !== !strm || grant !== eg ||
            ack !== ea || busy !== (m_owner >= 0)) begin
            errs++;
            $display("FAIL model at %0t: pixel %h/%h fd %b/%b grant %b/%b ack %b/%b busy %b/%b (got/exp)",
                     $time, pixel_out, m_pix, frame_done, !strm, grant, eg, ack, ea, busy, m_owner >= 0);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        model_step();
        @(negedge clk_out);
        check_model();
    endtask

    // Waits for grant, strobes every third cycle until ack, checking each pixel.
    task automatic do_frame(input int own, input logic [PS-1:0] col, input int chg_at,
                            input logic [PS-1:0] col2, input int drop_at, input bit reassert);
        int w = 0;
        int n = 0;
        bit got = 1'b0;
        while (grant === '0 && w < 12) begin tick(); w++; end
        chk("grant", {28'b0, grant}, 32'(1 << own));
        chk("frame_done_low", {31'b0, frame_done}, 0);
        while (!got && n < 20) begin
            px_strobe = 1'b1; tick(); px_strobe = 1'b0; n++;
            chk("pixel", {16'b0, pixel_out}, {16'b0, col});
            if (ack !== '0) begin
                got = 1'b1;
                chk("ack", {28'b0, ack}, 32'(1 << own));
                chk("frame_done_high", {31'b0, frame_done}, 1);
            end else begin
                if (n == chg_at)  color_in[own*PS +: PS] = col2;
                if (n == drop_at) req[own] = 1'b0;
                tick(); tick();
            end
        end
        chk("strobes_per_frame", n, RES);
        req[own] = 1'b0;
        tick();
        chk("ack_one_cycle", {28'b0, ack}, 0);
        chk("busy_after_done", {31'b0, busy}, 0);
        if (reassert) req[own] = 1'b1;
    endtask

    typedef struct {
        bit            r;
        logic [NR-1:0] rq;
        logic [PS-1:0] col;
        bit            stb;
        logic [NR-1:0] g;
        logic [NR-1:0] a;
        bit            fd;
        logic [PS-1:0] px;
        bit            bsy;
    } vec_t;

    vec_t tv [8];

    initial begin
        tv[0] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0};
        tv[1] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0};
        tv[2] = '{1'b1, 4'b0001, 16'hFFE0, 1'b0, 4'b0001, 4'b0000, 1'b0, 16'h0000, 1'b1};
        tv[3] = '{1'b1, 4'b0001, 16'hFFE0, 1'b1, 4'b0001, 4'b0000, 1'b0, 16'hFFE0, 1'b1};
        tv[4] = '{1'b1, 4'b0001, 16'h1234, 1'b0, 4'b0001, 4'b0000, 1'b0, 16'hFFE0, 1'b1};
        tv[5] = '{1'b1, 4'b0001, 16'h1234, 1'b1, 4'b0001, 4'b0000, 1'b0, 16'hFFE0, 1'b1};
        tv[6] = '{1'b0, 4'b0001, 16'h1234, 1'b0, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0};
        tv[7] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0};

        rst = 1'b0; req = '0; color_in = '0; px_strobe = 1'b0;

        for (int v = 0; v < 8; v++) begin
            rst = tv[v].r; req = tv[v].rq; color_in = {48'b0, tv[v].col}; px_strobe = tv[v].stb;
            tick();
            chk($sformatf("tv%0d_grant", v), {28'b0, grant}, {28'b0, tv[v].g});
            chk($sformatf("tv%0d_ack", v), {28'b0, ack}, {28'b0, tv[v].a});
            chk($sformatf("tv%0d_fd", v), {31'b0, frame_done}, {31'b0, tv[v].fd});
            chk($sformatf("tv%0d_pixel", v), {16'b0, pixel_out}, {16'b0, tv[v].px});
            chk($sformatf("tv%0d_busy", v), {31'b0, busy}, {31'b0, tv[v].bsy});
        end
        px_strobe = 1'b0;
        tick();

        // Single frame
        req = 4'b0001; color_in = {48'b0, 16'hFFE0};
        do_frame(0, 16'hFFE0, 0, 16'h0, 0, 1'b0);

        // Round robin from a fresh pointer
        rst = 1'b0; tick(); rst = 1'b1;
        color_in = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        req = 4'b1111;
        for (int k = 0; k < 5; k++)
            do_frame(k % NR, color_in[(k % NR)*PS +: PS], 0, 16'h0, 0, 1'b1);
        req = '0; tick(); tick();

        // Colour change mid-frame is ignored
        color_in[0 +: PS] = 16'h07FF; req = 4'b0001;
        do_frame(0, 16'h07FF, 3, 16'hF800, 0, 1'b0);

        // Owner releases req early; frame still completes
        color_in[0 +: PS] = 16'h1234; req = 4'b0001;
        do_frame(0, 16'h1234, 0, 16'h0, 2, 1'b0);

        // Reset mid-frame, then a complete fresh frame
        color_in[PS +: PS] = 16'hABCD; req = 4'b0010;
        for (int w = 0; w < 12 && grant === '0; w++) tick();
        for (int s = 0; s < 4; s++) begin
            px_strobe = 1'b1; tick(); px_strobe = 1'b0; tick(); tick();
        end
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rst_pixel", {16'b0, pixel_out}, 0);
        chk("rst_fd", {31'b0, frame_done}, 1);
        chk("rst_grant", {28'b0, grant}, 0);
        chk("rst_ack", {28'b0, ack}, 0);
        do_frame(1, 16'hABCD, 0, 16'h0, 0, 1'b0);

        // Strobes while idle
        req = '0;
        for (int s = 0; s < 4; s++) begin
            px_strobe = 1'b1; tick(); px_strobe = 1'b0; tick();
            chk("idle_pixel", {16'b0, pixel_out}, 32'hABCD);
            chk("idle_busy", {31'b0, busy}, 0);
            chk("idle_grant", {28'b0, grant}, 0);
        end

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(79) != 0);
            req       = ($urandom_range(3) == 0) ? '0 : NR'($urandom);
            color_in  = {$urandom, $urandom};
            px_strobe = ($urandom_range(1) == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
